bcd_down_counter: RTL and testbench



---
 rtl/bcd_down_counter_if.sv | 24 ++
 rtl/bcd_down_counter.sv | 112 +++++++++++
 tb/tb_bcd_down_counter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_down_counter_if.sv
// Control/status bundle for the BCD countdown timer: load/start/en in, packed BCD count and flags out.
// No backpressure: strobes are sampled every clk edge and flags are single-cycle pulses.
interface bcd_down_counter_if #(
   parameter int DIGITS = 2
);
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic                  start;
   logic                  en;
   logic [4*DIGITS-1:0]   q;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport master (
      output load, load_val, start, en,
      input  q, busy, done, err
   );

   modport slave (
      input  load, load_val, start, en,
      output q, busy, done, err
   );
endinterface

// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD countdown timer. Outputs are registered, 1-cycle latency. No backpressure.
// Define BCD_AUTO_RELOAD_EN to reload the last accepted preset at terminal count (periodic mode).
module bcd_down_counter #(
   parameter int DIGITS = 2
) (
   input  logic              clk,
   input  logic              rst,
   bcd_down_counter_if.slave bus
);
   localparam int W = 4 * DIGITS;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t         state;
   logic [W-1:0]   q;
   logic           busy;
   logic           done;
   logic           err;
`ifdef BCD_AUTO_RELOAD_EN
   logic [W-1:0]   reload;
`endif

   function automatic logic bcd_valid(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Ripple borrow: a zero digit wraps to 9 and passes the borrow upward.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         q     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
`ifdef BCD_AUTO_RELOAD_EN
         reload <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (bus.load) begin
            if (!bcd_valid(bus.load_val)) begin
               err <= 1'b1;
            end else begin
               q     <= bus.load_val;
               state <= IDLE;
               busy  <= 1'b0;
`ifdef BCD_AUTO_RELOAD_EN
               reload <= bus.load_val;
`endif
            end
         end else if (bus.start && state == IDLE) begin
            if (q == '0) begin
               done <= 1'b1;
            end else begin
               state <= RUN;
               busy  <= 1'b1;
            end
         end else if (state == RUN && bus.en) begin
            if (q == W'(1)) begin
               done <= 1'b1;
`ifdef BCD_AUTO_RELOAD_EN
               if (reload != '0) begin
                  q <= reload;
               end else begin
                  q     <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
               end
`else
               q     <= '0;
               state <= IDLE;
               busy  <= 1'b0;
`endif
            end else begin
               q <= bcd_dec(q);
            end
         end
      end
   end

   assign bus.q    = q;
   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.err  = err;
endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: decimal reference model feeds a scoreboard queue,
// scenario tables add fixed expectations taken from the intended behaviour.
module tb_bcd_down_counter;
   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;

   typedef struct packed {
      logic [W-1:0] q;
      logic         busy;
      logic         done;
      logic         err;
   } obs_t;

   typedef struct packed {
      logic         r;
      logic         ld;
      logic [W-1:0] lv;
      logic         st;
      logic         e;
      obs_t         req;
   } step_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bcd_down_counter_if #(.DIGITS(DIGITS)) bus ();

   bcd_down_counter #(.DIGITS(DIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   obs_t exp_q[$];

   int   m_q   = 0;
   bit   m_run = 1'b0;
`ifdef BCD_AUTO_RELOAD_EN
   int   m_rl  = 0;
`endif

   function automatic int bcd2int(input logic [W-1:0] v);
      int r;
      r = 0;
      for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic bit bcd_ok(input logic [W-1:0] v);
      for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int n);
      logic [W-1:0] r;
      int           x;
      r = '0;
      x = n;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Reference model works on plain integers; BCD only at the boundary.
   function automatic obs_t model_step(input bit r, input bit ld, input logic [W-1:0] lv,
                                       input bit st, input bit e);
      obs_t o;
      o = '0;
      if (r) begin
         m_q = 0; m_run = 1'b0;
`ifdef BCD_AUTO_RELOAD_EN
         m_rl = 0;
`endif
      end else if (ld) begin
         if (!bcd_ok(lv)) begin
            o.err = 1'b1;
         end else begin
            m_q = bcd2int(lv); m_run = 1'b0;
`ifdef BCD_AUTO_RELOAD_EN
            m_rl = m_q;
`endif
         end
      end else if (st && !m_run) begin
         if (m_q == 0) o.done = 1'b1;
         else m_run = 1'b1;
      end else if (m_run && e) begin
         m_q = m_q - 1;
         if (m_q == 0) begin
            o.done = 1'b1;
`ifdef BCD_AUTO_RELOAD_EN
            if (m_rl != 0) m_q = m_rl;
            else m_run = 1'b0;
`else
            m_run = 1'b0;
`endif
         end
      end
      o.q    = int2bcd(m_q);
      o.busy = m_run;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.q    = bus.q;
      o.busy = bus.busy;
      o.done = bus.done;
      o.err  = bus.err;
      return o;
   endfunction

   task automatic drive(input bit r, input bit ld, input logic [W-1:0] lv, input bit st, input bit e);
      @(negedge clk);
      rst          = r;
      bus.load     = ld;
      bus.load_val = lv;
      bus.start    = st;
      bus.en       = e;
      exp_q.push_back(model_step(r, ld, lv, st, e));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t o, ex;
      for (int c = 0; c < 4; c++) begin
         drive(c == 0, 1'b0, '0, 1'b0, 1'b0);
         o = sample(); ex = exp_q.pop_front(); n_checks++;
         if (o !== ex || o !== obs_t'('0)) begin
            n_fail++;
            $display("FAIL reset cycle %0d: got q=%h busy=%b done=%b err=%b, required q=00 busy=0 done=0 err=0",
                     c, o.q, o.busy, o.done, o.err);
         end
      end
   endtask

   task automatic test_countdown();
      obs_t     o, ex;
      int       n;
      bit       got_done;
      logic [W-1:0] fin_q;
      logic     fin_busy;
`ifdef BCD_AUTO_RELOAD_EN
      fin_q = 8'h25; fin_busy = 1'b1;
`else
      fin_q = 8'h00; fin_busy = 1'b0;
`endif
      n = 0; got_done = 1'b0;
      for (int s = 0; s < 2; s++) begin
         drive(1'b0, s == 0, 8'h25, s == 1, 1'b0);
         o = sample(); ex = exp_q.pop_front(); n_checks++;
         if (o !== ex || o.q !== 8'h25 || o.busy !== (s == 1)) begin
            n_fail++;
            $display("FAIL countdown setup %0d: got q=%h busy=%b done=%b err=%b, required q=%h busy=%b done=%b err=%b",
                     s, o.q, o.busy, o.done, o.err, ex.q, ex.busy, ex.done, ex.err);
         end
      end
      while (!got_done && n < 40) begin
         drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
         n++;
         o = sample(); ex = exp_q.pop_front(); n_checks++;
         if (o !== ex) begin
            n_fail++;
            $display("FAIL countdown step %0d: got q=%h busy=%b done=%b err=%b, required q=%h busy=%b done=%b err=%b",
                     n, o.q, o.busy, o.done, o.err, ex.q, ex.busy, ex.done, ex.err);
         end
         if (o.done === 1'b1) begin
            got_done = 1'b1;
            n_checks++;
            if (o.q !== fin_q || o.busy !== fin_busy) begin
               n_fail++;
               $display("FAIL countdown terminal: got q=%h busy=%b, required q=%h busy=%b",
                        o.q, o.busy, fin_q, fin_busy);
            end
         end
      end
      n_checks++;
      if (!got_done || n != 25) begin
         n_fail++;
         $display("FAIL countdown length: got %0d enabled cycles (done seen=%0d), required 25", n, got_done);
      end
   endtask

   task automatic test_enable();
      step_t t[6];
      obs_t  o, ex;
      t = '{'{0,1,8'h12,0,0,'{8'h12,1'b0,1'b0,1'b0}},
            '{0,0,8'h00,1,0,'{8'h12,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,1,'{8'h11,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,0,'{8'h11,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,0,'{8'h11,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,1,'{8'h10,1'b1,1'b0,1'b0}}};
      for (int i = 0; i < 6; i++) begin
         drive(t[i].r, t[i].ld, t[i].lv, t[i].st, t[i].e);
         o = sample(); ex = exp_q.pop_front(); n_checks++;
         if (o !== t[i].req || o !== ex) begin
            n_fail++;
            $display("FAIL enable step %0d: got q=%h busy=%b done=%b err=%b, required q=%h busy=%b done=%b err=%b",
                     i, o.q, o.busy, o.done, o.err, t[i].req.q, t[i].req.busy, t[i].req.done, t[i].req.err);
         end
      end
   endtask

   task automatic test_bad_load();
      step_t t[3];
      obs_t  o, ex;
      t = '{'{0,1,8'h3A,0,1,'{8'h10,1'b1,1'b0,1'b1}},
            '{0,0,8'h00,0,0,'{8'h10,1'b1,1'b0,1'b0}},
            '{0,1,8'h99,0,0,'{8'h99,1'b0,1'b0,1'b0}}};
      for (int i = 0; i < 3; i++) begin
         drive(t[i].r, t[i].ld, t[i].lv, t[i].st, t[i].e);
         o = sample(); ex = exp_q.pop_front(); n_checks++;
         if (o !== t[i].req || o !== ex) begin
            n_fail++;
            $display("FAIL bad_load step %0d: got q=%h busy=%b done=%b err=%b, required q=%h busy=%b done=%b err=%b",
                     i, o.q, o.busy, o.done, o.err, t[i].req.q, t[i].req.busy, t[i].req.done, t[i].req.err);
         end
      end
   endtask

   task automatic test_abort();
      step_t t[14];
      obs_t  o, ex;
      t = '{'{0,1,8'h09,0,0,'{8'h09,1'b0,1'b0,1'b0}},
            '{0,0,8'h00,1,0,'{8'h09,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,1,'{8'h08,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,1,'{8'h07,1'b1,1'b0,1'b0}},
            '{0,1,8'h40,0,1,'{8'h40,1'b0,1'b0,1'b0}},
            '{0,1,8'h09,0,0,'{8'h09,1'b0,1'b0,1'b0}},
            '{0,0,8'h00,1,0,'{8'h09,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,1,'{8'h08,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,1,'{8'h07,1'b1,1'b0,1'b0}},
            '{1,1,8'h55,1,1,'{8'h00,1'b0,1'b0,1'b0}},
            '{0,1,8'h02,0,0,'{8'h02,1'b0,1'b0,1'b0}},
            '{0,0,8'h00,1,1,'{8'h02,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,1,'{8'h01,1'b1,1'b0,1'b0}},
            '{0,1,8'h55,0,1,'{8'h55,1'b0,1'b0,1'b0}}};
      for (int i = 0; i < 14; i++) begin
         drive(t[i].r, t[i].ld, t[i].lv, t[i].st, t[i].e);
         o = sample(); ex = exp_q.pop_front(); n_checks++;
         if (o !== t[i].req || o !== ex) begin
            n_fail++;
            $display("FAIL abort step %0d: got q=%h busy=%b done=%b err=%b, required q=%h busy=%b done=%b err=%b",
                     i, o.q, o.busy, o.done, o.err, t[i].req.q, t[i].req.busy, t[i].req.done, t[i].req.err);
         end
      end
   endtask

   task automatic test_zero_start();
      step_t t[5];
      obs_t  o, ex;
      t = '{'{0,1,8'h00,0,0,'{8'h00,1'b0,1'b0,1'b0}},
            '{0,0,8'h00,1,0,'{8'h00,1'b0,1'b1,1'b0}},
            '{0,0,8'h00,0,1,'{8'h00,1'b0,1'b0,1'b0}},
            '{0,0,8'h00,1,1,'{8'h00,1'b0,1'b1,1'b0}},
            '{0,0,8'h00,0,0,'{8'h00,1'b0,1'b0,1'b0}}};
      for (int i = 0; i < 5; i++) begin
         drive(t[i].r, t[i].ld, t[i].lv, t[i].st, t[i].e);
         o = sample(); ex = exp_q.pop_front(); n_checks++;
         if (o !== t[i].req || o !== ex) begin
            n_fail++;
            $display("FAIL zero_start step %0d: got q=%h busy=%b done=%b err=%b, required q=%h busy=%b done=%b err=%b",
                     i, o.q, o.busy, o.done, o.err, t[i].req.q, t[i].req.busy, t[i].req.done, t[i].req.err);
         end
      end
   endtask

`ifdef BCD_AUTO_RELOAD_EN
   task automatic test_auto_reload();
      step_t t[10];
      obs_t  o, ex;
      t = '{'{0,1,8'h03,0,0,'{8'h03,1'b0,1'b0,1'b0}},
            '{0,0,8'h00,1,0,'{8'h03,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,1,'{8'h02,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,1,'{8'h01,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,1,'{8'h03,1'b1,1'b1,1'b0}},
            '{0,0,8'h00,0,1,'{8'h02,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,1,'{8'h01,1'b1,1'b0,1'b0}},
            '{0,0,8'h00,0,1,'{8'h03,1'b1,1'b1,1'b0}},
            '{0,1,8'h00,0,0,'{8'h00,1'b0,1'b0,1'b0}},
            '{0,0,8'h00,1,0,'{8'h00,1'b0,1'b1,1'b0}}};
      for (int i = 0; i < 10; i++) begin
         drive(t[i].r, t[i].ld, t[i].lv, t[i].st, t[i].e);
         o = sample(); ex = exp_q.pop_front(); n_checks++;
         if (o !== t[i].req || o !== ex) begin
            n_fail++;
            $display("FAIL auto_reload step %0d: got q=%h busy=%b done=%b err=%b, required q=%h busy=%b done=%b err=%b",
                     i, o.q, o.busy, o.done, o.err, t[i].req.q, t[i].req.busy, t[i].req.done, t[i].req.err);
         end
      end
   endtask
`endif

   task automatic test_back_to_back();
      obs_t         o, ex;
      bit           r, ld, st, e;
      logic [W-1:0] lv;
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 59) == 0);
         ld = ($urandom_range(0, 9) == 0);
         st = ($urandom_range(0, 3) == 0);
         e  = ($urandom_range(0, 3) != 0);
         lv = ($urandom_range(0, 2) == 0) ? W'($urandom) : int2bcd($urandom_range(0, 6));
         drive(r, ld, lv, st, e);
         o = sample(); ex = exp_q.pop_front(); n_checks++;
         if (o !== ex) begin
            n_fail++;
            $display("FAIL back_to_back cycle %0d: got q=%h busy=%b done=%b err=%b, required q=%h busy=%b done=%b err=%b",
                     i, o.q, o.busy, o.done, o.err, ex.q, ex.busy, ex.done, ex.err);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.load     = 1'b0;
      bus.load_val = '0;
      bus.start    = 1'b0;
      bus.en       = 1'b0;
      test_reset();
      test_countdown();
      test_enable();
      test_bad_load();
      test_abort();
      test_zero_start();
`ifdef BCD_AUTO_RELOAD_EN
      test_auto_reload();
`endif
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
